// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its round-robin front end:
// operation codes, arbiter state encoding and small decode helpers.
package alu_pkg;

  // Operation codes understood by the ALU datapath
  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_SLL = 4'b0100;
  localparam logic [3:0] ALUC_SRL = 4'b0101;
  localparam logic [3:0] ALUC_SRA = 4'b0110;
  localparam logic [3:0] ALUC_ADD = 4'b1000;
  localparam logic [3:0] ALUC_SUB = 4'b1001;
  localparam logic [3:0] ALUC_MUL = 4'b1010;
  localparam logic [3:0] ALUC_DIV = 4'b1011;

  // Arbiter operation state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply and divide are the only operations with a multi-cycle latency
  function automatic logic is_muldiv(input logic [3:0] aluc);
    return (aluc == ALUC_MUL) || (aluc == ALUC_DIV);
  endfunction

  // Codes with no assigned operation; their result is forced to zero
  function automatic logic is_undef_code(input logic [3:0] aluc);
    return (aluc == 4'b0011) || (aluc == 4'b0111) || (aluc[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by all requesters of alu_arbiter.
// All operands are treated as unsigned; results are truncated to 32 bits.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  aluc_i,
  output logic [31:0] res_o
);

  logic shiftOut;

  // A shift distance of 32 or more moves every bit out of the word
  assign shiftOut = (b_i >= 32'd32);

  // Operation decode; the arithmetic shift code behaves as a logical shift
  // because the operand is unsigned, so it shares the SRL datapath
  always_comb begin
    res_o = '0;
    case (aluc_i)
      ALUC_AND: res_o = a_i & b_i;
      ALUC_OR:  res_o = a_i | b_i;
      ALUC_XOR: res_o = a_i ^ b_i;
      ALUC_SLL: res_o = shiftOut ? '0 : (a_i << b_i[4:0]);
      ALUC_SRL,
      ALUC_SRA: res_o = shiftOut ? '0 : (a_i >> b_i[4:0]);
      ALUC_ADD: res_o = a_i + b_i;
      ALUC_SUB: res_o = a_i - b_i;
      ALUC_MUL: res_o = a_i * b_i;
      ALUC_DIV: res_o = (b_i == '0) ? '0 : (a_i / b_i);
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one alu among NREQ requesters.
// A granted request has its operands captured, runs for one cycle (or
// MULDIV_LAT cycles for multiply/divide) and its result is held until the
// owning requester accepts it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int MULDIV_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [4*NREQ-1:0]    req_aluc,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_res,
  output logic                 busy
);

  localparam int         IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] MD_CNT = 4'(MULDIV_LAT - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [3:0]        aluc_q, aluc_d;
  logic [31:0]       res_q, res_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [NREQ-1:0]   grant;
  logic [31:0]       sel_a, sel_b;
  logic [3:0]        sel_aluc;
  logic [31:0]       alu_res;
  logic [31:0]       res_final;

  // Search upward from ptr (wrapping) for the first pending request.
  // Returns {found, index}.
  function automatic logic [IW:0] rr_select(input logic [NREQ-1:0] v,
                                             input logic [IW-1:0]   ptr);
    logic [IW:0] sel;
    int          idx;
    sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!sel[IW] && v[idx]) begin
        sel = {1'b1, IW'(idx)};
      end
    end
    return sel;
  endfunction

  assign {pick_found, pick_idx} = rr_select(req_valid, rr_q);

  // Operand slice of the requester currently winning arbitration
  assign sel_a    = req_a[32*int'(pick_idx) +: 32];
  assign sel_b    = req_b[32*int'(pick_idx) +: 32];
  assign sel_aluc = req_aluc[4*int'(pick_idx) +: 4];

  // One-hot grant, only offered while no operation is in flight
  always_comb begin
    grant = '0;
    if ((state_q == IDLE) && pick_found) begin
      grant[pick_idx] = 1'b1;
    end
  end

  // The ALU only ever sees captured operands, so late changes on the
  // request ports cannot disturb an operation in progress
  alu u_alu (
    .a_i    (a_q),
    .b_i    (b_q),
    .aluc_i (aluc_q),
    .res_o  (alu_res)
  );

  // Result overrides: divide-by-zero saturates, unassigned codes read zero
  always_comb begin
    res_final = alu_res;
    if ((aluc_q == ALUC_DIV) && (b_q == '0)) begin
      res_final = '1;
    end else if (is_undef_code(aluc_q)) begin
      res_final = '0;
    end
  end

  // Next-state and register-update logic for the IDLE/EXEC/DONE sequence
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    aluc_d      = aluc_q;
    res_d       = res_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          a_d     = sel_a;
          b_d     = sel_b;
          aluc_d  = sel_aluc;
          owner_d = pick_idx;
          cnt_d   = is_muldiv(sel_aluc) ? MD_CNT : 4'd0;
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d                = res_final;
          rsp_valid_d          = '0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = DONE;
        end
      end
      DONE: begin
        if (rsp_ready[owner_q]) begin
          rr_d        = IW'((int'(owner_q) + 1) % NREQ);
          rsp_valid_d = '0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      aluc_q      <= '0;
      res_q       <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      aluc_q      <= aluc_d;
      res_q       <= res_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = res_q;
  assign busy      = busy_q;

endmodule
